// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request strobe per request; exactly one response strobe per request.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns pcF, single-outstanding imem requests, IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stallF,
    input  logic                stallD,
    input  logic                flushD,
    input  logic                pcsrcD,
    input  logic [31:0]         pcbranchD,
    input  logic                jumpD,
    input  logic [31:0]         pcjumpD,
    fetch_stage_if.master       imem,
    output logic [31:0]         instrD,
    output logic [5:0]          opD,
    output logic [5:0]          functD,
    output logic [31:0]         pcplus4D,
    output logic                validD,
    output logic                fetch_busyF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         squash_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pcF, r_hold_instr, r_hold_pc;
    logic        r_squash, w_squash_nxt;

    logic [31:0] w_target, w_word, w_word_pc, w_pc_nxt;
    logic        w_redirect, w_resp, w_resp_live, w_have_word, w_to_ifid;
    logic        w_capture, w_discard, w_outstanding, w_buf_full, w_issue;

    always_comb begin
        w_redirect  = !stallD && (jumpD || pcsrcD);
        w_target    = jumpD ? pcjumpD : pcbranchD;
        w_resp      = (r_state == S_WAIT) && imem.imem_valid;
        w_resp_live = w_resp && !r_squash;
        w_have_word = w_resp_live || (r_state == S_HOLD);
        w_word      = (r_state == S_HOLD) ? r_hold_instr : imem.imem_rdata;
        w_word_pc   = (r_state == S_HOLD) ? r_hold_pc : r_pcF;
        w_to_ifid   = w_have_word && !stallD && !w_redirect;
        w_capture   = w_resp_live && stallD;
        // A squashed stale response counts as discarded, same as redirect/flush drops.
        w_discard   = (w_have_word && w_redirect) || (w_to_ifid && flushD) || (w_resp && r_squash);

        w_pc_nxt = r_pcF;
        if (w_redirect)
            w_pc_nxt = w_target;
        else if (w_to_ifid)
            w_pc_nxt = w_word_pc + 32'd4;

        // Occupancy after this cycle decides whether a new request may go out now.
        w_outstanding = (r_state == S_WAIT) && !w_resp;
        w_buf_full    = w_capture || ((r_state == S_HOLD) && stallD);
        w_issue       = !stallF && !reset && !w_outstanding && !w_buf_full;

        w_state_nxt = S_IDLE;
        if (w_outstanding || w_issue)
            w_state_nxt = S_WAIT;
        else if (w_buf_full)
            w_state_nxt = S_HOLD;

        w_squash_nxt = (r_state == S_WAIT) && !w_resp && (r_squash || w_redirect);
    end

    assign imem.imem_req  = w_issue;
    assign imem.imem_addr = w_pc_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pcF        <= RESET_PC;
            r_squash     <= 1'b0;
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
            instrD       <= NOP_INSTR;
            pcplus4D     <= 32'd0;
            validD       <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pcF    <= w_pc_nxt;
            r_squash <= w_squash_nxt;
            if (w_capture) begin
                r_hold_instr <= imem.imem_rdata;
                r_hold_pc    <= r_pcF;
            end
            if (flushD) begin
                instrD <= NOP_INSTR;
                validD <= 1'b0;
            end else if (!stallD) begin
                if (w_to_ifid) begin
                    instrD   <= w_word;
                    pcplus4D <= w_word_pc + 32'd4;
                    validD   <= 1'b1;
                end else begin
                    instrD <= NOP_INSTR;
                    validD <= 1'b0;
                end
            end
        end
    end

    assign opD         = instrD[31:26];
    assign functD      = instrD[5:0];
    assign fetch_busyF = (r_state != S_IDLE);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count  <= 32'd0;
            squash_count <= 32'd0;
        end else begin
            if (w_to_ifid && !flushD)
                fetch_count <= fetch_count + 32'd1;
            if (w_discard)
                squash_count <= squash_count + 32'd1;
        end
    end
`else
    logic w_unused_discard;
    assign w_unused_discard = w_discard;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: imem model answers addr+0x100 after mem_lat cycles;
// a negedge monitor pops expected requests/instructions from scoreboard queues.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0;
    logic        pcsrcD = 1'b0, jumpD = 1'b0;
    logic [31:0] pcbranchD = 32'd0, pcjumpD = 32'd0;
    logic [31:0] instrD, pcplus4D;
    logic [5:0]  opD, functD;
    logic        validD, fetch_busyF;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count, squash_count;
`endif

    always #5 clk = ~clk;

    fetch_stage_if imem_if();

    fetch_stage dut (
        .clk(clk), .reset(reset), .stallF(stallF), .stallD(stallD), .flushD(flushD),
        .pcsrcD(pcsrcD), .pcbranchD(pcbranchD), .jumpD(jumpD), .pcjumpD(pcjumpD),
        .imem(imem_if), .instrD(instrD), .opD(opD), .functD(functD),
        .pcplus4D(pcplus4D), .validD(validD), .fetch_busyF(fetch_busyF)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fetch_count), .squash_count(squash_count)
`endif
    );

    typedef struct packed { logic [31:0] instr; logic [31:0] pc4; } exp_t;
    logic [31:0] exp_addr[$];
    exp_t        exp_ins[$];
    int          n_vec = 0, n_err = 0;
    int          mem_lat = 1;
    logic        ld = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ins(input logic [31:0] ins, input logic [31:0] pc4);
        exp_t e;
        e.instr = ins;
        e.pc4   = pc4;
        exp_ins.push_back(e);
    endtask

    // IF/ID was written at the last edge when not stalled or when flushed.
    always @(posedge clk) ld <= !stallD || flushD;

    // Instruction memory model: one outstanding request, fixed latency.
    initial begin : mem
        int          cnt;
        logic        pend;
        logic        req_l;
        logic [31:0] req_a, a;
        cnt = 0; pend = 1'b0; a = 32'd0;
        imem_if.imem_valid = 1'b0;
        imem_if.imem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            req_l = imem_if.imem_req;
            req_a = imem_if.imem_addr;
            tick();
            imem_if.imem_valid = 1'b0;
            if (req_l) begin
                pend = 1'b1;
                cnt  = mem_lat;
                a    = req_a;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_if.imem_valid = 1'b1;
                    imem_if.imem_rdata = a + 32'h100;
                    pend = 1'b0;
                end
            end
        end
    end

    // Monitor: every request and every newly loaded valid instruction is scored.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (imem_if.imem_req === 1'b1) begin
                if (exp_addr.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL req_extra: got addr %h want no request", imem_if.imem_addr);
                end else
                    chk("req_addr", imem_if.imem_addr, exp_addr.pop_front());
            end
            if (ld && validD === 1'b1) begin
                if (exp_ins.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL instr_extra: got instrD %h want bubble", instrD);
                end else begin
                    exp_t e;
                    e = exp_ins.pop_front();
                    chk("instrD", instrD, e.instr);
                    chk("pcplus4D", pcplus4D, e.pc4);
                    chk("opD", 32'(opD), 32'(e.instr[31:26]));
                end
            end
        end
    end

    initial begin : stim
        // Reset values
        tick(); tick();
        @(negedge clk);
        chk("rst_req", 32'(imem_if.imem_req), 32'd0);
        chk("rst_instrD", instrD, 32'd0);
        chk("rst_validD", 32'(validD), 32'd0);
        chk("rst_pcplus4D", pcplus4D, 32'd0);
        chk("rst_busy", 32'(fetch_busyF), 32'd0);

        // Streaming with 1-cycle memory
        exp_addr.push_back(32'h0); exp_addr.push_back(32'h4); exp_addr.push_back(32'h8);
        push_ins(32'h100, 32'h4); push_ins(32'h104, 32'h8); push_ins(32'h108, 32'hC);
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("first_req", 32'(imem_if.imem_req), 32'd1);
        tick(); tick(); tick(); stallF = 1'b1;
        tick(); tick();
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, 32'd3);
`endif

        // stallD holds a response in the buffer
        exp_addr.push_back(32'hC); push_ins(32'h10C, 32'h10);
        tick(); stallF = 1'b0;
        tick(); stallD = 1'b1;
        tick();
        @(negedge clk);
        chk("hold_busy", 32'(fetch_busyF), 32'd1);
        chk("hold_noreq", 32'(imem_if.imem_req), 32'd0);
        tick();
        @(negedge clk);
        chk("hold_validD", 32'(validD), 32'd0);
        tick(); stallD = 1'b0; stallF = 1'b1;
        tick(); tick();

        // Branch during WAIT with 3-cycle memory
        mem_lat = 3;
        exp_addr.push_back(32'h10); exp_addr.push_back(32'h40); push_ins(32'h140, 32'h44);
        tick(); stallF = 1'b0;
        tick(); stallF = 1'b1; pcsrcD = 1'b1; pcbranchD = 32'h40;
        tick(); pcsrcD = 1'b0; stallF = 1'b0;
        tick();
        tick(); stallF = 1'b1;
        tick(); tick(); tick(); tick();
`ifdef FETCH_PERF_CNT_EN
        chk("squash_br", squash_count, 32'd1);
`endif

        // Jump has priority over branch
        mem_lat = 1;
        exp_addr.push_back(32'h44); exp_addr.push_back(32'h80); push_ins(32'h180, 32'h84);
        tick(); stallF = 1'b0;
        tick(); jumpD = 1'b1; pcsrcD = 1'b1; pcjumpD = 32'h80; pcbranchD = 32'h40;
        tick(); jumpD = 1'b0; pcsrcD = 1'b0; stallF = 1'b1;
        tick(); tick();

        // flushD on the delivery cycle
        exp_addr.push_back(32'h84); exp_addr.push_back(32'h88); push_ins(32'h188, 32'h8C);
        tick(); stallF = 1'b0;
        tick(); flushD = 1'b1; stallF = 1'b1;
        tick(); flushD = 1'b0; stallF = 1'b0;
        @(negedge clk);
        chk("flush_instrD", instrD, 32'd0);
        chk("flush_validD", 32'(validD), 32'd0);
        tick(); stallF = 1'b1;
        tick(); tick();
`ifdef FETCH_PERF_CNT_EN
        chk("squash_flush", squash_count, 32'd3);
`endif

        // Reset with a request outstanding; late response must be ignored
        mem_lat = 3;
        exp_addr.push_back(32'h8C);
        tick(); stallF = 1'b0;
        tick(); stallF = 1'b1; reset = 1'b1; mem_lat = 1;
        tick();
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("late_busy", 32'(fetch_busyF), 32'd0);
        chk("late_validD", 32'(validD), 32'd0);
        exp_addr.push_back(32'h0); push_ins(32'h100, 32'h4);
        tick(); stallF = 1'b0;
        tick(); stallF = 1'b1;
        tick(); tick();
`ifdef FETCH_PERF_CNT_EN
        chk("squash_rst", squash_count, 32'd0);
        chk("fetch_rst", fetch_count, 32'd1);
`endif

        chk("addr_q_empty", 32'(exp_addr.size()), 32'd0);
        chk("ins_q_empty", 32'(exp_ins.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
